// File: rtl/parity_ctrl_pkg.sv
// Shared encodings for the frame parity controller: FSM states and parity-sense constants.
package parity_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PAR    = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_word_xor.sv
// Combinational XOR reduction of one data word.
module parity_word_xor #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] i_word,
    output logic              o_par
);

    assign o_par = ^i_word;

endmodule

// File: rtl/parity_frame_ctrl.sv
// Folds word parities over a frame of 1..MAX_WORDS words and checks them against a
// trailing parity bit, reporting one done/err result per frame.
module parity_frame_ctrl
    import parity_ctrl_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int MAX_WORDS = 16,
    parameter int ODD       = 0,
    localparam int CNT_W    = $clog2(MAX_WORDS + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_frame_len,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    input  logic              i_par_valid,
    input  logic              i_par_bit,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_word_cnt,
    output logic              o_done,
    output logic              o_err,
    output logic              o_len_err,
    output logic [1:0]        o_state
);

    localparam logic ACC_INIT = (ODD != 0) ? PAR_ODD : PAR_EVEN;

    // Stream handshake: a word moves on any edge where in_valid and in_ready are both high;
    // in_ready is high exactly while in DATA, and an unaccepted word stays with the upstream.
    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_acc;
    logic               r_err;
    logic               r_len_err;
    logic               w_word_par;
    logic               w_len_ok;
    logic               w_start_ok;
    logic               w_accept;
    logic [CNT_W-1:0]   w_cnt_inc;

    parity_word_xor #(.DATA_W(DATA_W)) u_word_xor (
        .i_word (i_in_data),
        .o_par  (w_word_par)
    );

    assign w_len_ok   = (i_frame_len != '0) && (i_frame_len <= CNT_W'(MAX_WORDS));
    assign w_start_ok = (r_state == ST_IDLE) && i_start && w_len_ok;
    assign w_accept   = (r_state == ST_DATA) && i_in_valid;
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_start_ok) w_state_nxt = ST_DATA;
            ST_DATA:   if (w_accept && (w_cnt_inc == r_len)) w_state_nxt = ST_PAR;
            ST_PAR:    if (i_par_valid) w_state_nxt = ST_REPORT;
            ST_REPORT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_len     <= '0;
            r_cnt     <= '0;
            r_acc     <= ACC_INIT;
            r_err     <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            r_len_err <= (r_state == ST_IDLE) && i_start && !w_len_ok;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_len <= i_frame_len;
                        r_cnt <= '0;
                        r_acc <= ACC_INIT;
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_acc <= r_acc ^ w_word_par;
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_PAR: begin
                    if (i_par_valid) r_err <= r_acc ^ i_par_bit;
                end
                default: ;
            endcase
        end
    end

    // All outputs come straight from flops or a decode of the state register.
    assign o_in_ready = (r_state == ST_DATA);
    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = (r_state == ST_REPORT);
    assign o_err      = (r_state == ST_REPORT) && r_err;
    assign o_len_err  = r_len_err;
    assign o_word_cnt = r_cnt;
    assign o_state    = r_state;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Directed bench for parity_frame_ctrl: an even-sense and an odd-sense instance share all
// inputs; a negedge monitor pops expected frame results whenever done is presented.
module tb_parity_frame_ctrl;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 5;
    localparam int W      = CNT_W + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  frame_len = '0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              par_valid = 1'b0;
    logic              par_bit = 1'b0;

    logic              ev_in_ready, ev_busy, ev_done, ev_err, ev_len_err;
    logic [CNT_W-1:0]  ev_word_cnt;
    logic [1:0]        ev_state;
    logic              od_in_ready, od_busy, od_done, od_err, od_len_err;
    logic [CNT_W-1:0]  od_word_cnt;
    logic [1:0]        od_state;

    parity_frame_ctrl #(.DATA_W(DATA_W), .MAX_WORDS(16), .ODD(0)) u_even (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_frame_len(frame_len),
        .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(ev_in_ready),
        .i_par_valid(par_valid), .i_par_bit(par_bit), .o_busy(ev_busy),
        .o_word_cnt(ev_word_cnt), .o_done(ev_done), .o_err(ev_err),
        .o_len_err(ev_len_err), .o_state(ev_state)
    );

    parity_frame_ctrl #(.DATA_W(DATA_W), .MAX_WORDS(16), .ODD(1)) u_odd (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_frame_len(frame_len),
        .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(od_in_ready),
        .i_par_valid(par_valid), .i_par_bit(par_bit), .o_busy(od_busy),
        .o_word_cnt(od_word_cnt), .o_done(od_done), .o_err(od_err),
        .o_len_err(od_len_err), .o_state(od_state)
    );

    int n_vec  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        check({name, " busy"},     {ev_busy, od_busy}, 0);
        check({name, " in_ready"}, {ev_in_ready, od_in_ready}, 0);
        check({name, " done"},     {ev_done, od_done}, 0);
        check({name, " err"},      {ev_err, od_err}, 0);
        check({name, " len_err"},  {ev_len_err, od_len_err}, 0);
        check({name, " word_cnt"}, {ev_word_cnt, od_word_cnt}, 0);
        check({name, " state"},    {ev_state, od_state}, 0);
    endtask

    // Result monitor: {word_cnt, even err, odd err} per done pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            check("done agree", od_done, ev_done);
            if (ev_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected done", 1, 0);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    check("frame result", {ev_word_cnt, ev_err, od_err}, e);
                end
            end else begin
                check("err idle", {ev_err, od_err}, 0);
            end
        end
    end

    task automatic push_word(input logic [DATA_W-1:0] w, input bit stray, input logic stray_bit);
        int guard;
        repeat ($urandom_range(0, stray ? 3 : 1)) begin
            in_valid  = 1'b0;
            par_valid = stray;
            par_bit   = stray_bit;
            step();
        end
        par_valid = 1'b0;
        in_valid  = 1'b1;
        in_data   = w;
        guard = 0;
        @(negedge clk);
        while (!ev_in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!ev_in_ready) check("in_ready timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_par(input logic pb, input logic [CNT_W-1:0] cnt, input logic exp_even);
        exp_q.push_back({cnt, exp_even, ~exp_even});
        par_valid = 1'b1;
        par_bit   = pb;
        step();
        par_valid = 1'b0;
    endtask

    task automatic run_frame(input int len, input logic [63:0] words, input logic pb,
                             input logic exp_even, input bit stray);
        logic [CNT_W-1:0] l;
        l = CNT_W'(len);
        start     = 1'b1;
        frame_len = l;
        step();
        start = 1'b0;
        for (int i = 0; i < len; i++) push_word(words[i*4 +: 4], stray, ~pb);
        send_par(pb, l, exp_even);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        check_idle("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;
        step();

        // 1011 (1) ^ 0001 (1) = 0; par 0 -> even ok, odd error
        run_frame(2, 64'h1B, 1'b0, 1'b0, 1'b0);
        check("word_cnt hold idle", ev_word_cnt, 2);
        check("busy after frame", ev_busy, 0);
        // same words, par 1 -> even error, odd ok
        run_frame(2, 64'h1B, 1'b1, 1'b1, 1'b0);
        // 7 (1), 3 (0), 5 (0) -> 1; par 1 -> even ok
        run_frame(3, 64'h537, 1'b1, 1'b0, 1'b0);

        // 16 words 0..F: eight odd-weight nibbles -> acc 0; par 1 -> even error
        start     = 1'b1;
        frame_len = 5'd16;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) push_word(4'(i), 1'b1, 1'b1);
        in_valid = 1'b1;
        in_data  = 4'hF;
        check("len16 in_ready drop", ev_in_ready, 0);
        check("len16 word_cnt", ev_word_cnt, 16);
        step();
        check("len16 extra not taken", ev_word_cnt, 16);
        in_valid = 1'b0;
        send_par(1'b1, 5'd16, 1'b1);
        step();

        // illegal lengths
        start     = 1'b1;
        frame_len = 5'd0;
        step();
        start = 1'b0;
        check("len0 len_err", {ev_len_err, od_len_err}, 2'b11);
        check("len0 busy", {ev_busy, od_busy}, 0);
        step();
        check("len0 pulse end", ev_len_err, 0);
        check("len0 busy later", ev_busy, 0);
        start     = 1'b1;
        frame_len = 5'd17;
        step();
        start = 1'b0;
        check("len17 len_err", {ev_len_err, od_len_err}, 2'b11);
        check("len17 busy", {ev_busy, od_busy}, 0);
        step();
        check("len17 pulse end", ev_len_err, 0);

        // reset mid-frame after 3 of 8 words
        start     = 1'b1;
        frame_len = 5'd8;
        step();
        start = 1'b0;
        push_word(4'h1, 1'b0, 1'b0);
        push_word(4'h2, 1'b0, 1'b0);
        push_word(4'h3, 1'b0, 1'b0);
        check("pre-reset word_cnt", ev_word_cnt, 3);
        rst_n = 1'b0;
        step();
        check_idle("mid reset");
        rst_n = 1'b1;
        step();
        // 0110 (0); par 1 -> even error, odd ok
        run_frame(1, 64'h6, 1'b1, 1'b1, 1'b0);

        // start held high across two frames
        start     = 1'b1;
        frame_len = 5'd2;
        step();
        push_word(4'h1, 1'b0, 1'b0);
        push_word(4'h2, 1'b0, 1'b0);
        check("held start PAR", {ev_busy, ev_in_ready}, 2'b10);
        frame_len = 5'd3;
        send_par(1'b0, 5'd2, 1'b0);
        step();
        check("held start idle", ev_busy, 0);
        step();
        check("held start restart", ev_in_ready, 1);
        check("held start cnt clear", ev_word_cnt, 0);
        start = 1'b0;
        // 8 (1), 0 (0), E (1) -> 0; par 1 -> even error
        push_word(4'h8, 1'b0, 1'b0);
        push_word(4'h0, 1'b0, 1'b0);
        push_word(4'hE, 1'b0, 1'b0);
        send_par(1'b1, 5'd3, 1'b1);
        step();
        step();
        check("final idle", ev_busy, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check("results outstanding", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
